vec_sched: RTL and testbench

Phase sequencer for the Tanimoto datapath. It sits downstream of the vector concatenation stage and consumes complete fingerprint vectors. On `i_Start` it routes the first `i_RefCount` vectors into the reference buffer, addressed sequentially. It then forwards the next `i_CmpCount` vectors to the comparator pipeline with a valid/ready handshake and running vector IDs, and signals completion.

---
 rtl/vec_sched.sv | 166 ++++++++++++++++
 tb/tb_vec_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sched.sv
// vec_sched: phase sequencer in front of the Tanimoto comparator.
// A run first streams RefCount vectors into the reference buffer at
// sequential addresses. It then passes CmpCount vectors to the comparator
// through a one-entry valid/ready output register, tagging each one with
// a running ID, and pulses o_Done at the end.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | after reset, waiting for i_Start
//   LOAD_REF | accepting reference vectors, one buffer write per beat
//   COMPARE  | forwarding compare vectors through the output register
//   DONE     | run finished, o_Done on the first cycle, waits for i_Start
module vec_sched #(
  parameter int VECTOR_WIDTH   = 128,
  parameter int VEC_ID_WIDTH   = 8,
  parameter int REF_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_Start,
  input  logic [REF_ADDR_WIDTH:0]   i_RefCount,
  input  logic [VEC_ID_WIDTH-1:0]   i_CmpCount,
  input  logic [VECTOR_WIDTH-1:0]   i_Vector,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  output logic                      o_RefWe,
  output logic [REF_ADDR_WIDTH-1:0] o_RefAddr,
  output logic [VECTOR_WIDTH-1:0]   o_RefData,
  output logic [VECTOR_WIDTH-1:0]   o_CmpVector,
  output logic [VEC_ID_WIDTH-1:0]   o_CmpID,
  output logic                      o_CmpValid,
  input  logic                      i_CmpReady,
  output logic                      o_Busy,
  output logic                      o_Done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_REF = 2'd1,
    S_COMPARE  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [REF_ADDR_WIDTH:0] REF_ONE = (REF_ADDR_WIDTH + 1)'(1);
  localparam logic [VEC_ID_WIDTH-1:0] ID_ONE  = VEC_ID_WIDTH'(1);

  state_t                    state_q;
  // Reference counter and the index of the last reference beat. One bit
  // wider than the address so a full buffer of 2^REF_ADDR_WIDTH fits.
  logic [REF_ADDR_WIDTH:0]   ref_cnt_q;
  logic [REF_ADDR_WIDTH:0]   ref_last_q;
  logic [REF_ADDR_WIDTH:0]   ref_last_d;
  // Compare ID counter and number of compare beats still to accept.
  logic [VEC_ID_WIDTH-1:0]   cmp_cnt_q;
  logic [VEC_ID_WIDTH-1:0]   cmp_rem_q;

  logic                      ref_we_q;
  logic [REF_ADDR_WIDTH-1:0] ref_addr_q;
  logic [VECTOR_WIDTH-1:0]   ref_data_q;
  logic [VECTOR_WIDTH-1:0]   cmp_vec_q;
  logic [VEC_ID_WIDTH-1:0]   cmp_id_q;
  logic                      cmp_valid_q;
  logic                      done_q;

  logic                      ready_c;
  logic                      cmp_accept;
  logic                      cmp_fire;

  // A zero reference count is illegal; it is handled like a count of one.
  assign ref_last_d = (i_RefCount == '0) ? '0 : (i_RefCount - REF_ONE);

  // Input acceptance: always open while loading references. While comparing,
  // open only if beats remain and the output register is free or draining
  // this cycle, which keeps full throughput with no bubble.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_LOAD_REF: ready_c = 1'b1;
      S_COMPARE:  ready_c = (cmp_rem_q != '0) && (!cmp_valid_q || i_CmpReady);
      default:    ready_c = 1'b0;
    endcase
  end

  assign cmp_accept = (state_q == S_COMPARE) && i_Valid && ready_c;
  assign cmp_fire   = cmp_valid_q && i_CmpReady;

  // Sequencer FSM with registered buffer-write and comparator outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ref_cnt_q   <= '0;
      ref_last_q  <= '0;
      cmp_cnt_q   <= '0;
      cmp_rem_q   <= '0;
      ref_we_q    <= 1'b0;
      ref_addr_q  <= '0;
      ref_data_q  <= '0;
      cmp_vec_q   <= '0;
      cmp_id_q    <= '0;
      cmp_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ref_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_Start) begin
            ref_last_q <= ref_last_d;
            cmp_rem_q  <= i_CmpCount;
            ref_cnt_q  <= '0;
            cmp_cnt_q  <= '0;
            state_q    <= S_LOAD_REF;
          end
        end

        S_LOAD_REF: begin
          if (i_Valid) begin
            ref_we_q   <= 1'b1;
            ref_addr_q <= ref_cnt_q[REF_ADDR_WIDTH-1:0];
            ref_data_q <= i_Vector;
            ref_cnt_q  <= ref_cnt_q + REF_ONE;
            if (ref_cnt_q == ref_last_q) begin
              if (cmp_rem_q != '0) begin
                state_q <= S_COMPARE;
              end else begin
                // No compare phase: o_Done lines up with the last write.
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end

        S_COMPARE: begin
          if (cmp_accept) begin
            // Covers the fire-and-replace case as well.
            cmp_vec_q   <= i_Vector;
            cmp_id_q    <= cmp_cnt_q;
            cmp_valid_q <= 1'b1;
            cmp_cnt_q   <= cmp_cnt_q + ID_ONE;
            cmp_rem_q   <= cmp_rem_q - ID_ONE;
          end else if (cmp_fire) begin
            cmp_valid_q <= 1'b0;
            if (cmp_rem_q == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Ready     = ready_c;
  assign o_RefWe     = ref_we_q;
  assign o_RefAddr   = ref_addr_q;
  assign o_RefData   = ref_data_q;
  assign o_CmpVector = cmp_vec_q;
  assign o_CmpID     = cmp_id_q;
  assign o_CmpValid  = cmp_valid_q;
  assign o_Busy      = (state_q == S_LOAD_REF) || (state_q == S_COMPARE);
  assign o_Done      = done_q;

endmodule

// File: tb/tb_vec_sched.sv
// Bench for vec_sched. Each run is checked against a transaction-level
// model: the list of vectors offered, how many have been accepted and how
// many compare outputs have fired decide every expected output.
module tb_vec_sched;
  localparam int VW = 128;
  localparam int IW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_Start;
  logic [AW:0]   i_RefCount;
  logic [IW-1:0] i_CmpCount;
  logic [VW-1:0] i_Vector;
  logic          i_Valid;
  logic          o_Ready;
  logic          o_RefWe;
  logic [AW-1:0] o_RefAddr;
  logic [VW-1:0] o_RefData;
  logic [VW-1:0] o_CmpVector;
  logic [IW-1:0] o_CmpID;
  logic          o_CmpValid;
  logic          i_CmpReady;
  logic          o_Busy;
  logic          o_Done;

  int checks   = 0;
  int failures = 0;
  logic [VW-1:0] vec[$];

  vec_sched #(.VECTOR_WIDTH(VW), .VEC_ID_WIDTH(IW), .REF_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_RefCount(i_RefCount),
    .i_CmpCount(i_CmpCount), .i_Vector(i_Vector), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .o_RefWe(o_RefWe), .o_RefAddr(o_RefAddr),
    .o_RefData(o_RefData), .o_CmpVector(o_CmpVector), .o_CmpID(o_CmpID),
    .o_CmpValid(o_CmpValid), .i_CmpReady(i_CmpReady), .o_Busy(o_Busy),
    .o_Done(o_Done)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete run. vmode: 0 valid always, 1 random, 2 pattern 1,0,0,1.
  // rmode: 0 ready always, 1 random, 2 hold ready low 5 cycles on ID 1.
  // b2b: return in the o_Done cycle so the next run starts right there.
  task automatic run(input int refcnt, input int cmpcnt, input int vmode,
                     input int rmode, input bit b2b, input string name);
    int eff_ref, n_vec, acc, fired, acc_cmp, cyc, bp_cnt, we_addr;
    bit exp_valid, exp_ready, accepted, we_exp, done_ok;
    eff_ref = (refcnt == 0) ? 1 : refcnt;
    n_vec   = eff_ref + cmpcnt;
    vec.delete();
    for (int k = 0; k < n_vec; k++) vec.push_back(rand_vec());
    i_Start    = 1'b1;
    i_RefCount = refcnt[AW:0];
    i_CmpCount = cmpcnt[IW-1:0];
    i_Valid    = 1'b0;
    i_Vector   = rand_vec();
    i_CmpReady = 1'b1;
    @(posedge clk); #1;
    i_Start    = 1'b0;
    i_RefCount = (AW + 1)'($urandom);
    i_CmpCount = IW'($urandom);
    acc = 0; fired = 0; cyc = 0; bp_cnt = 0; we_exp = 0; we_addr = 0; done_ok = 0;
    while (!done_ok && cyc < 3000) begin
      case (vmode)
        0:       i_Valid = 1'b1;
        1:       i_Valid = ($urandom_range(0, 3) != 0);
        default: i_Valid = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      i_Start  = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_Vector = (acc < n_vec) ? vec[acc] : rand_vec();
      case (rmode)
        0: i_CmpReady = 1'b1;
        1: i_CmpReady = 1'($urandom_range(0, 1));
        default: begin
          if (o_CmpValid && o_CmpID == 8'd1 && bp_cnt < 5) begin
            i_CmpReady = 1'b0;
            bp_cnt++;
          end else begin
            i_CmpReady = 1'b1;
          end
        end
      endcase
      #1;
      acc_cmp   = (acc > eff_ref) ? (acc - eff_ref) : 0;
      exp_valid = (acc_cmp > fired);
      exp_ready = (acc < eff_ref) || ((acc < n_vec) && (!exp_valid || i_CmpReady));
      checks++;
      if (o_Busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy cyc=%0d: got %b want 1", name, cyc, o_Busy);
      end
      checks++;
      if (o_Done !== 1'b0) begin
        failures++;
        $display("FAIL %s early_done cyc=%0d: got %b want 0", name, cyc, o_Done);
      end
      checks++;
      if (o_Ready !== exp_ready) begin
        failures++;
        $display("FAIL %s ready cyc=%0d: got %b want %b", name, cyc, o_Ready, exp_ready);
      end
      checks++;
      if (o_CmpValid !== exp_valid) begin
        failures++;
        $display("FAIL %s cmp_valid cyc=%0d: got %b want %b", name, cyc, o_CmpValid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (o_CmpID !== fired[IW-1:0]) begin
          failures++;
          $display("FAIL %s cmp_id cyc=%0d: got %0d want %0d", name, cyc, o_CmpID, fired);
        end
        checks++;
        if (o_CmpVector !== vec[eff_ref + fired]) begin
          failures++;
          $display("FAIL %s cmp_vec id=%0d: got %h want %h", name, fired, o_CmpVector, vec[eff_ref + fired]);
        end
      end
      checks++;
      if (o_RefWe !== we_exp) begin
        failures++;
        $display("FAIL %s ref_we cyc=%0d: got %b want %b", name, cyc, o_RefWe, we_exp);
      end
      if (we_exp) begin
        checks++;
        if (o_RefAddr !== we_addr[AW-1:0] || o_RefData !== vec[we_addr]) begin
          failures++;
          $display("FAIL %s ref_write: got addr %0d data %h want addr %0d data %h", name, o_RefAddr, o_RefData, we_addr, vec[we_addr]);
        end
      end
      accepted = i_Valid && exp_ready;
      we_exp   = accepted && (acc < eff_ref);
      we_addr  = acc;
      if (exp_valid && i_CmpReady) fired++;
      if (accepted) acc++;
      @(posedge clk); #1;
      cyc++;
      if (acc == n_vec && fired == cmpcnt) done_ok = 1;
    end
    i_Start = 1'b0;
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL %s timeout: got acc=%0d fired=%0d want acc=%0d fired=%0d", name, acc, fired, n_vec, cmpcnt);
    end else begin
      checks++;
      if ({o_Done, o_Busy, o_CmpValid, o_Ready, o_RefWe} !== {1'b1, 1'b0, 1'b0, 1'b0, we_exp}) begin
        failures++;
        $display("FAIL %s done_cycle {done,busy,cvalid,ready,we}: got %b want %b", name,
                 {o_Done, o_Busy, o_CmpValid, o_Ready, o_RefWe}, {1'b1, 1'b0, 1'b0, 1'b0, we_exp});
      end
      if (we_exp) begin
        checks++;
        if (o_RefAddr !== we_addr[AW-1:0] || o_RefData !== vec[we_addr]) begin
          failures++;
          $display("FAIL %s last_ref_write: got addr %0d want %0d", name, o_RefAddr, we_addr);
        end
      end
      if (!b2b) begin
        // An extra vector offered after the run must be refused.
        i_Valid  = 1'b1;
        i_Vector = rand_vec();
        #1;
        checks++;
        if (o_Ready !== 1'b0) begin
          failures++;
          $display("FAIL %s ready_after_run: got %b want 0", name, o_Ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({o_Done, o_Busy, o_RefWe, o_CmpValid, o_Ready} !== 5'b0) begin
          failures++;
          $display("FAIL %s post_done {done,busy,we,cvalid,ready}: got %b want 00000", name,
                   {o_Done, o_Busy, o_RefWe, o_CmpValid, o_Ready});
        end
        i_Valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_Start    = 1'($urandom_range(0, 1));
      i_RefCount = (AW + 1)'($urandom);
      i_CmpCount = IW'($urandom);
      i_Vector   = rand_vec();
      i_Valid    = 1'($urandom_range(0, 1));
      i_CmpReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if ({o_Ready, o_RefWe, o_RefAddr, o_RefData, o_CmpVector, o_CmpID, o_CmpValid, o_Busy, o_Done} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d cvalid=%b id=%0d busy=%b done=%b want all 0",
                 o_Ready, o_RefWe, o_RefAddr, o_CmpValid, o_CmpID, o_Busy, o_Done);
      end
    end
    i_Start = 1'b0;
    i_Valid = 1'b1;
    rstn    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_Ready, o_Busy, o_RefWe} !== 3'b000) begin
        failures++;
        $display("FAIL reset_idle {ready,busy,we}: got %b want 000", {o_Ready, o_Busy, o_RefWe});
      end
    end
    i_Valid = 1'b0;
  endtask

  task automatic test_basic();
    run(3, 4, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run(1, 3, 0, 2, 1'b0, "backpressure");
  endtask

  task automatic test_bursty();
    run(2, 3, 2, 0, 1'b0, "bursty");
    run(4, 5, 2, 1, 1'b0, "bursty_rdy");
  endtask

  task automatic test_edge_counts();
    run(16, 0, 0, 0, 1'b0, "ref16_cmp0");
    run(0, 2, 0, 0, 1'b0, "ref0");
    run(0, 0, 2, 0, 1'b0, "ref0_cmp0");
  endtask

  task automatic test_back_to_back();
    run(2, 2, 0, 0, 1'b1, "b2b_first");
    run(3, 1, 1, 1, 1'b1, "b2b_second");
    run(1, 0, 0, 0, 1'b0, "b2b_third");
  endtask

  task automatic test_abort();
    int  cyc;
    bit  hit;
    i_Start    = 1'b1;
    i_RefCount = 5'd2;
    i_CmpCount = 8'd5;
    i_Valid    = 1'b0;
    i_CmpReady = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    i_Valid = 1'b1;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < 20) begin
      i_Vector = rand_vec();
      @(posedge clk); #1;
      cyc++;
      if (o_CmpValid && o_CmpID == 8'd1) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach_id1: got no ID 1 within %0d cycles want ID 1", cyc);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_Ready, o_RefWe, o_RefAddr, o_RefData, o_CmpVector, o_CmpID, o_CmpValid, o_Busy, o_Done} !== '0) begin
      failures++;
      $display("FAIL abort_clear: got ready=%b cvalid=%b id=%0d busy=%b done=%b want all 0",
               o_Ready, o_CmpValid, o_CmpID, o_Busy, o_Done);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_Done, o_Busy} !== 2'b00) begin
      failures++;
      $display("FAIL abort_no_done {done,busy}: got %b want 00", {o_Done, o_Busy});
    end
    rstn    = 1'b1;
    i_Valid = 1'b0;
    @(posedge clk); #1;
    run(3, 3, 0, 0, 1'b0, "abort_rerun");
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      run($urandom_range(0, 16), $urandom_range(0, 12), $urandom_range(0, 2),
          $urandom_range(0, 1), (r != 11) ? 1'($urandom_range(0, 1)) : 1'b0, "random");
    end
  endtask

  initial begin
    rstn       = 1'b0;
    i_Start    = 1'b0;
    i_RefCount = '0;
    i_CmpCount = '0;
    i_Vector   = '0;
    i_Valid    = 1'b0;
    i_CmpReady = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_bursty();
    test_edge_counts();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
